// File: rtl/bmp_load_ctrl_if.sv
// rtl/bmp_load_ctrl_if.sv - byte stream input and RAM write bus of the BMP load controller
interface bmp_load_ctrl_if #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 20
);
    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  RAM_valid;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [BYTE_WIDTH-1:0] ram_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, RAM_valid, ram_addr, ram_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, RAM_valid, ram_addr, ram_data
    );
endinterface

// File: rtl/bmp_load_ctrl.sv
// rtl/bmp_load_ctrl.sv - streams a BMP file into frame RAM while parsing and validating its header
module bmp_load_ctrl #(
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned BMP_TOTAL_SIZE = 786486,
    parameter int unsigned HEADER_SIZE    = 54
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    bmp_load_ctrl_if.slave    bus,
    output logic [31:0]       file_size,
    output logic [31:0]       data_offset,
    output logic [31:0]       bmp_width,
    output logic [31:0]       bmp_height,
    output logic [15:0]       bpp,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXEL, S_DONE, S_ERROR} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_HDR = ADDR_WIDTH'(HEADER_SIZE - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]           fsize_q, fsize_d;
    logic [31:0]           doff_q, doff_d;
    logic [31:0]           width_q, width_d;
    logic [31:0]           height_q, height_d;
    logic [15:0]           bpp_q, bpp_d;
    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [BYTE_WIDTH-1:0] wr_data_q;

    logic                  in_ready_w;
    logic                  accept;
    logic                  restart;
    logic                  header_ok;
    logic                  last_pixel;
    logic [1:0]            lane;
    logic [7:0]            byte_w;

    function automatic logic at(input int unsigned lo, input int unsigned hi);
        at = (32'(cnt_q) >= lo) && (32'(cnt_q) <= hi);
    endfunction

    assign in_ready_w = (state_q == S_HEADER) || (state_q == S_PIXEL);
    assign accept     = bus.in_valid && in_ready_w;
    assign restart    = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign byte_w     = bus.in_data[7:0];
    // Every 4-byte field starts at an offset = 2 mod 4, so the lane falls out of the low counter bits.
    assign lane       = cnt_q[1:0] - 2'd2;

    assign header_ok  = (fsize_q >= HEADER_SIZE) && (fsize_q <= BMP_TOTAL_SIZE) &&
                        (doff_q >= HEADER_SIZE) && (doff_q < fsize_q) && (bpp_q == 16'd24);
    assign last_pixel = (32'(cnt_q) == fsize_q - 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fsize_d  = fsize_q;
        doff_d   = doff_q;
        width_d  = width_q;
        height_d = height_q;
        bpp_d    = bpp_q;
        if (restart) begin
            state_d  = S_HEADER;
            cnt_d    = '0;
            fsize_d  = '0;
            doff_d   = '0;
            width_d  = '0;
            height_d = '0;
            bpp_d    = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_HEADER) begin
                if (at(2, 5))   fsize_d[{lane, 3'b000} +: 8]  = byte_w;
                if (at(10, 13)) doff_d[{lane, 3'b000} +: 8]   = byte_w;
                if (at(18, 21)) width_d[{lane, 3'b000} +: 8]  = byte_w;
                if (at(22, 25)) height_d[{lane, 3'b000} +: 8] = byte_w;
                if (at(28, 29)) bpp_d[{cnt_q[0], 3'b000} +: 8] = byte_w;
                if (at(0, 0) && byte_w != 8'h42) state_d = S_ERROR;
                if (at(1, 1) && byte_w != 8'h4D) state_d = S_ERROR;
                // Byte 53 carries no field data, so the registered fields are already complete here.
                if (cnt_q == LAST_HDR) begin
                    if (!header_ok)                 state_d = S_ERROR;
                    else if (fsize_q == HEADER_SIZE) state_d = S_DONE;
                    else                             state_d = S_PIXEL;
                end
            end else if (state_q == S_PIXEL && last_pixel) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fsize_q    <= '0;
            doff_q     <= '0;
            width_q    <= '0;
            height_q   <= '0;
            bpp_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fsize_q    <= fsize_d;
            doff_q     <= doff_d;
            width_q    <= width_d;
            height_q   <= height_d;
            bpp_q      <= bpp_d;
            wr_valid_q <= accept;
            if (accept) begin
                wr_addr_q <= cnt_q;
                wr_data_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.RAM_valid = wr_valid_q;
    assign bus.ram_addr  = wr_addr_q;
    assign bus.ram_data  = wr_data_q;
    assign file_size     = fsize_q;
    assign data_offset   = doff_q;
    assign bmp_width     = width_q;
    assign bmp_height    = height_q;
    assign bpp           = bpp_q;
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERROR);
endmodule

// File: tb/tb_bmp_load_ctrl.sv
// tb/tb_bmp_load_ctrl.sv - randomized self-checking bench for bmp_load_ctrl against a file-level model
module tb_bmp_load_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] file_size, data_offset, bmp_width, bmp_height;
    logic [15:0] bpp;
    logic        done, err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fbuf [0:511];
    logic [19:0] wq_addr [$];
    logic [7:0]  wq_data [$];

    bmp_load_ctrl_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) bus ();

    bmp_load_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .file_size  (file_size),
        .data_offset(data_offset),
        .bmp_width  (bmp_width),
        .bmp_height (bmp_height),
        .bpp        (bpp),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.RAM_valid) begin
            wq_addr.push_back(bus.ram_addr);
            wq_data.push_back(bus.ram_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] le(input int off, input int nb, input int n);
        logic [31:0] r = 0;
        for (int k = 0; k < nb; k++)
            if (off + k < n) r = r | (32'(fbuf[off + k]) << (8 * k));
        return r;
    endfunction

    // Reference: how many bytes the file should yield and whether it ends in DONE.
    task automatic model(output int n, output bit ok);
        logic [31:0] fs, off, bp;
        ok = 1'b0;
        if (fbuf[0] != 8'h42)      n = 1;
        else if (fbuf[1] != 8'h4D) n = 2;
        else begin
            fs  = le(2, 4, 54);
            off = le(10, 4, 54);
            bp  = le(28, 2, 54);
            if (fs >= 54 && fs <= 786486 && off >= 54 && off < fs && bp == 24) begin
                n = int'(fs);
                ok = 1'b1;
            end else n = 54;
        end
    endtask

    task automatic put32(input int off, input logic [31:0] v);
        for (int k = 0; k < 4; k++) fbuf[off + k] = v[8*k +: 8];
    endtask

    // kinds: 0 valid 4x4, 1 bad 2nd sig byte, 2 size too big, 3 bpp 8,
    //        4 random valid size, 5 bad 1st sig byte, 6 offset == size
    task automatic build_file(input int kind);
        logic [31:0] fs, off;
        for (int i = 0; i < 512; i++) fbuf[i] = 8'($urandom);
        fs  = 102;
        off = 54;
        if (kind == 2) fs = 786487;
        if (kind == 4) begin
            fs  = 54 + $urandom_range(1, 200);
            off = $urandom_range(54, fs - 1);
        end
        if (kind == 6) off = fs;
        fbuf[0] = 8'h42;
        fbuf[1] = (kind == 1) ? 8'h4E : 8'h4D;
        if (kind == 5) fbuf[0] = 8'($urandom_range(0, 8'h41));
        put32(2, fs);
        put32(10, off);
        put32(18, (kind == 4) ? $urandom_range(1, 512) : 32'd4);
        put32(22, (kind == 4) ? $urandom_range(1, 512) : 32'd4);
        fbuf[28] = (kind == 3) ? 8'd8 : 8'd24;
        fbuf[29] = 8'd0;
    endtask

    task automatic run_load(input int kind, input int vprob, input int start_at);
        int n, idx, cyc;
        bit ok;
        build_file(kind);
        model(n, ok);
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", 32'(done), 0);
        chk("restart_err", 32'(err), 0);
        chk("header_ready", 32'(bus.in_ready), 1);
        idx = 0;
        cyc = 0;
        while (!(done || err) && cyc < 4000) begin
            start = (idx == start_at);
            bus.in_valid = ($urandom_range(0, 99) < vprob);
            bus.in_data  = fbuf[idx & 511];
            if (bus.in_valid && bus.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("timeout", 32'(cyc < 4000), 1);
        bus.in_valid = 1'b1;
        repeat (8) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("status_done", 32'(done), 32'(ok));
        chk("status_err", 32'(err), 32'(!ok));
        chk("idle_ready", 32'(bus.in_ready), 0);
        chk("accepted", 32'(idx), 32'(n));
        chk("write_count", 32'(wq_addr.size()), 32'(n));
        for (int i = 0; i < wq_addr.size() && i < n; i++) begin
            chk("wr_addr", 32'(wq_addr[i]), 32'(i));
            chk("wr_data", 32'(wq_data[i]), 32'(fbuf[i]));
        end
        chk("file_size", file_size, le(2, 4, n));
        chk("data_offset", data_offset, le(10, 4, n));
        chk("bmp_width", bmp_width, le(18, 4, n));
        chk("bmp_height", bmp_height, le(22, 4, n));
        chk("bpp", 32'(bpp), le(28, 2, n));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_ramv"}, 32'(bus.RAM_valid), 0);
        chk({tag, "_addr"}, 32'(bus.ram_addr), 0);
        chk({tag, "_data"}, 32'(bus.ram_data), 0);
        chk({tag, "_fields"}, file_size | data_offset | bmp_width | bmp_height | 32'(bpp), 0);
        chk({tag, "_status"}, {30'd0, done, err}, 0);
    endtask

    task automatic reset_mid_load();
        int idx = 0, cyc = 0;
        build_file(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (idx < 71 && cyc < 500) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fbuf[idx];
            if (bus.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach71", 32'(idx), 71);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post_rst_writes", 32'(wq_addr.size()), 0);
        chk("post_rst_done", 32'(done), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");
        run_load(0, 100, -1);
        run_load(1, 100, -1);
        run_load(2, 100, -1);
        run_load(3, 100, -1);
        run_load(0, 50, -1);
        reset_mid_load();
        run_load(0, 100, -1);
        run_load(0, 70, 80);
        run_load(4, 60, -1);
        for (int r = 0; r < 8; r++)
            run_load($urandom_range(0, 6), $urandom_range(30, 100), -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
